// File: rtl/multi_counter.sv
// multi_counter: N-channel W-bit up/down counter bank with wrap/saturate mode; MULTI_COUNTER_ASSERT_EN embeds SVA properties
module multi_counter #(
  parameter int W = 10,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           mode,
  input  logic [N-1:0]   en,
  input  logic [N-1:0]   dir,
  input  logic [N-1:0]   load,
  input  logic [N*W-1:0] load_val,
  output logic [N*W-1:0] count,
  output logic [N-1:0]   tc,
  output logic [N-1:0]   ovf
);
  logic [N-1:0][W-1:0] cnt_q, cnt_d, step;
  logic [N-1:0]        tc_q, tc_d, ovf_q, ovf_d, bnd;
  for (genvar i = 0; i < N; i++) begin : g_ch
    assign bnd[i]   = dir[i] ? cnt_q[i] == '0 : cnt_q[i] == '1;
    assign step[i]  = dir[i] ? cnt_q[i] - W'(1) : cnt_q[i] + W'(1);
    assign cnt_d[i] = load[i] ? load_val[i*W +: W] : (en[i] && !(bnd[i] && mode)) ? step[i] : cnt_q[i];
    assign tc_d[i]  = !load[i] && en[i] && bnd[i];
`ifdef MULTI_COUNTER_ASSERT_EN
    a_sat_up: assert property (@(posedge clk) disable iff (rst || clr)
      mode && en[i] && !load[i] && !dir[i] && cnt_q[i] == '1 |=> cnt_q[i] != '0);
    a_sat_dn: assert property (@(posedge clk) disable iff (rst || clr)
      mode && en[i] && !load[i] && dir[i] && cnt_q[i] == '0 |=> cnt_q[i] != '1);
    a_ovf_sticky: assert property (@(posedge clk) disable iff (rst || clr)
      ovf_q[i] |=> ovf_q[i]);
    a_tc_ovf: assert property (@(posedge clk) disable iff (rst || clr)
      tc_q[i] |-> ovf_q[i]);
    a_live: assert property (@(posedge clk) disable iff (rst || clr)
      !mode && en[i] && !dir[i] && !load[i] |-> s_eventually tc_q[i]);
    c_full: cover property (@(posedge clk) disable iff (rst || clr) cnt_q[i] == '1);
`endif
  end
  assign ovf_d = ovf_q | tc_d;
  // state update: rst and clr both return every channel to zero
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
      tc_q  <= '0;
      ovf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end
  assign count = cnt_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
endmodule

// File: tb/tb_multi_counter.sv
// tb_multi_counter: directed vectors with a queue scoreboard for multi_counter (W=4, N=2)
module tb_multi_counter;
  logic       clk = 0;
  logic       rst = 1, clr = 0, mode = 0;
  logic [1:0] en = 0, dir = 0, load = 0;
  logic [7:0] load_val = 0;
  logic [7:0] count;
  logic [1:0] tc, ovf;
  int checks = 0, failures = 0, vec = 0;

  typedef struct {
    logic [7:0] c;
    logic [1:0] t;
    logic [1:0] o;
    int         id;
  } exp_t;
  exp_t q[$];

  multi_counter #(.W(4), .N(2)) dut (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode), .en(en), .dir(dir),
    .load(load), .load_val(load_val), .count(count), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // drive one cycle of inputs and queue the expected outputs after the next edge
  task automatic step(input logic r, c, m, input logic [1:0] e, d, l,
                      input logic [7:0] lv, input logic [7:0] ec,
                      input logic [1:0] et, eo);
    exp_t x;
    @(negedge clk);
    rst = r; clr = c; mode = m; en = e; dir = d; load = l; load_val = lv;
    x.c = ec; x.t = et; x.o = eo; x.id = vec++;
    q.push_back(x);
  endtask

  // monitor: every edge that has a queued expectation is compared
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      checks++;
      if (count !== x.c) begin
        failures++;
        $display("FAIL count vec%0d: got %h expected %h", x.id, count, x.c);
      end
      checks++;
      if (tc !== x.t) begin
        failures++;
        $display("FAIL tc vec%0d: got %b expected %b", x.id, tc, x.t);
      end
      checks++;
      if (ovf !== x.o) begin
        failures++;
        $display("FAIL ovf vec%0d: got %b expected %b", x.id, ovf, x.o);
      end
    end
  end

  initial begin
    // reset then count ch0 up
    step(1, 0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
    step(1, 0, 0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
    for (int k = 1; k <= 5; k++)
      step(0, 0, 0, 2'b01, 2'b00, 2'b00, 8'h00, 8'(k), 2'b00, 2'b00);
    // wrap up on ch0
    step(0, 0, 0, 2'b00, 2'b00, 2'b01, 8'h0E, 8'h0E, 2'b00, 2'b00);
    step(0, 0, 0, 2'b01, 2'b00, 2'b00, 8'h00, 8'h0F, 2'b00, 2'b00);
    step(0, 0, 0, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 2'b01, 2'b01);
    step(0, 0, 0, 2'b01, 2'b00, 2'b00, 8'h00, 8'h01, 2'b00, 2'b01);
    // saturate down on ch1; load keeps ovf
    step(0, 0, 0, 2'b00, 2'b00, 2'b10, 8'h10, 8'h11, 2'b00, 2'b01);
    step(0, 0, 1, 2'b10, 2'b10, 2'b00, 8'h00, 8'h01, 2'b00, 2'b01);
    for (int k = 0; k < 3; k++)
      step(0, 0, 1, 2'b10, 2'b10, 2'b00, 8'h00, 8'h01, 2'b10, 2'b11);
    // load beats en; clr beats load and en
    step(0, 0, 0, 2'b01, 2'b00, 2'b01, 8'h07, 8'h07, 2'b00, 2'b11);
    step(0, 1, 0, 2'b11, 2'b00, 2'b11, 8'hAB, 8'h00, 2'b00, 2'b00);
    // direction and mode changes mid-run
    for (int k = 1; k <= 3; k++)
      step(0, 0, 0, 2'b01, 2'b00, 2'b00, 8'h00, 8'(k), 2'b00, 2'b00);
    for (int k = 2; k >= 0; k--)
      step(0, 0, 0, 2'b01, 2'b01, 2'b00, 8'h00, 8'(k), 2'b00, 2'b00);
    step(0, 0, 0, 2'b01, 2'b01, 2'b00, 8'h00, 8'h0F, 2'b01, 2'b01);
    step(0, 0, 0, 2'b01, 2'b00, 2'b00, 8'h00, 8'h00, 2'b01, 2'b01);
    step(0, 0, 1, 2'b01, 2'b01, 2'b00, 8'h00, 8'h00, 2'b01, 2'b01);
    step(0, 0, 1, 2'b01, 2'b01, 2'b00, 8'h00, 8'h00, 2'b01, 2'b01);
    // saturate up on ch1, then release enable
    step(0, 0, 0, 2'b00, 2'b00, 2'b10, 8'hF0, 8'hF0, 2'b00, 2'b01);
    step(0, 0, 1, 2'b10, 2'b00, 2'b00, 8'h00, 8'hF0, 2'b10, 2'b11);
    step(0, 0, 1, 2'b00, 2'b00, 2'b00, 8'h00, 8'hF0, 2'b00, 2'b11);
    // reset mid-operation, then resume and hold
    step(0, 0, 0, 2'b11, 2'b00, 2'b00, 8'h00, 8'h01, 2'b10, 2'b11);
    step(1, 0, 0, 2'b11, 2'b00, 2'b11, 8'h55, 8'h00, 2'b00, 2'b00);
    step(0, 0, 0, 2'b11, 2'b00, 2'b00, 8'h00, 8'h11, 2'b00, 2'b00);
    step(0, 0, 0, 2'b00, 2'b01, 2'b00, 8'h00, 8'h11, 2'b00, 2'b00);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
